// File: rtl/addsub_serial_if.sv
// Handshake and data bundle for the serial adder/subtractor.
// master: operand producer / result consumer; slave: the arithmetic unit.
interface addsub_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start_valid, op_sub, a, b, done_ready,
    input  start_ready, result, carry, overflow, zero, negative, done_valid
  );

  modport slave (
    input  start_valid, op_sub, a, b, done_ready,
    output start_ready, result, carry, overflow, zero, negative, done_valid
  );
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle two's-complement adder/subtractor, CHUNK bits per clock, LSB first.
// Optional feature macro: ADDSUB_SERIAL_SAT_EN (saturate result on signed overflow).
// Sequence per operation: accept -> WIDTH/CHUNK chunk cycles -> one finalise cycle -> DONE.
module addsub_serial #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  addsub_serial_if.slave bus
);

  localparam int unsigned NumChunks = WIDTH / CHUNK;
  // Counter spans 0..NumChunks; the last value is the finalise cycle.
  localparam int unsigned CntW = $clog2(NumChunks + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("addsub_serial: illegal WIDTH/CHUNK combination");
  end

  state_t           state_q;
  cnt_t             cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_run_q;
  logic             cout_q;
  logic             ovf_q;
  logic             start_ready_q;
  logic             done_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;
`ifdef ADDSUB_SERIAL_SAT_EN
  logic             a_msb_q;
`endif

  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_res;

  // One chunk of ripple addition plus the shift of its sum into the accumulator.
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK + 1)'(carry_run_q);
    // Carry into the chunk's top bit; on the final chunk this is the carry into the MSB.
    msb_cin   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ chunk_sum[CHUNK-1];
    acc_next  = (acc_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Result as presented to the consumer: wrapped, or clamped when saturation is built in.
  always_comb begin
`ifdef ADDSUB_SERIAL_SAT_EN
    // Overflow implies both addends share a's sign, so a's MSB picks the clamp direction.
    if (ovf_q) begin
      final_res = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      final_res = acc_q;
    end
`else
    final_res = acc_q;
`endif
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      carry_run_q   <= 1'b0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      start_ready_q <= 1'b1;
      done_valid_q  <= 1'b0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      negative_q    <= 1'b0;
`ifdef ADDSUB_SERIAL_SAT_EN
      a_msb_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start_valid && start_ready_q) begin
            a_q           <= bus.a;
            b_q           <= bus.op_sub ? ~bus.b : bus.b;
            carry_run_q   <= bus.op_sub;
            acc_q         <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b0;
            state_q       <= StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == cnt_t'(NumChunks)) begin
            result_q     <= final_res;
            carry_q      <= cout_q;
            overflow_q   <= ovf_q;
            zero_q       <= (final_res == '0);
            negative_q   <= final_res[WIDTH-1];
            done_valid_q <= 1'b1;
            state_q      <= StDone;
          end else begin
            a_q         <= a_q >> CHUNK;
            b_q         <= b_q >> CHUNK;
            acc_q       <= acc_next;
            carry_run_q <= chunk_sum[CHUNK];
            cnt_q       <= cnt_q + cnt_t'(1);
            if (cnt_q == cnt_t'(NumChunks - 1)) begin
              cout_q  <= chunk_sum[CHUNK];
              ovf_q   <= msb_cin ^ chunk_sum[CHUNK];
`ifdef ADDSUB_SERIAL_SAT_EN
              a_msb_q <= a_q[CHUNK-1];
`endif
            end
          end
        end
        StDone: begin
          if (bus.done_ready) begin
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q       <= StIdle;
          start_ready_q <= 1'b1;
          done_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.done_valid  = done_valid_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.overflow    = overflow_q;
  assign bus.zero        = zero_q;
  assign bus.negative    = negative_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (CHUNK = 4, 1, 8; WIDTH = 8) share one stimulus.
module tb_addsub_serial;

  localparam int unsigned W = 8;
`ifdef ADDSUB_SERIAL_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t         e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start_valid;
  logic op_sub;
  logic done_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         sr[3];
  logic         dv[3];
  logic         c_o[3];
  logic         v_o[3];
  logic         z_o[3];
  logic         n_o[3];
  logic [W-1:0] r_o[3];

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned C = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
    addsub_serial_if #(.WIDTH(W)) bus ();
    assign bus.start_valid = start_valid;
    assign bus.op_sub      = op_sub;
    assign bus.a           = a;
    assign bus.b           = b;
    assign bus.done_ready  = done_ready;
    assign sr[g]  = bus.start_ready;
    assign dv[g]  = bus.done_valid;
    assign r_o[g] = bus.result;
    assign c_o[g] = bus.carry;
    assign v_o[g] = bus.overflow;
    assign z_o[g] = bus.zero;
    assign n_o[g] = bus.negative;
    addsub_serial #(.WIDTH(W), .CHUNK(C)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic int lat_of(input int g);
    return (g == 0) ? 3 : ((g == 1) ? 9 : 2);
  endfunction

  // Reference: full-width arithmetic on 9 bits.
  function automatic exp_t model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy   = op ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, op};
    e.c  = full[W];
    e.v  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    e.res = full[W-1:0];
    if (Sat && e.v) e.res = x[W-1] ? 8'h80 : 8'h7F;
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, g, act, req);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    for (int g = 0; g < 3; g++) begin
      check({tag, ".result"}, g, 32'(r_o[g]), 32'(e.res));
      check({tag, ".carry"}, g, 32'(c_o[g]), 32'(e.c));
      check({tag, ".overflow"}, g, 32'(v_o[g]), 32'(e.v));
      check({tag, ".zero"}, g, 32'(z_o[g]), 32'(e.z));
      check({tag, ".negative"}, g, 32'(n_o[g]), 32'(e.n));
    end
  endtask

  // One full operation on all three DUTs; hold = cycles of done_ready=0 after all are done.
  task automatic run_op(input logic op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input exp_t e, input int hold);
    bit   seen[3];
    int   lat[3];
    exp_t got;
    sb_q.push_back(e);
    @(negedge clk);
    for (int g = 0; g < 3; g++) check("pre_accept.start_ready", g, 32'(sr[g]), 32'd1);
    start_valid = 1'b1;
    op_sub      = op;
    a           = va;
    b           = vb;
    done_ready  = 1'b0;
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      seen[g] = 1'b0;
      lat[g]  = -1;
    end
    for (int t = 1; t <= 20 && !(seen[0] && seen[1] && seen[2]); t++) begin
      // Garbage on operands and stray start pulses must not disturb the operation.
      start_valid = 1'($urandom_range(0, 1));
      op_sub      = 1'($urandom_range(0, 1));
      a           = 8'($urandom);
      b           = 8'($urandom);
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (!seen[g] && dv[g]) begin
          seen[g] = 1'b1;
          lat[g]  = t;
        end
      end
    end
    for (int g = 0; g < 3; g++) check("latency", g, 32'(lat[g]), 32'(lat_of(g)));
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_outputs("op", got);
      for (int i = 0; i < hold; i++) begin
        start_valid = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
          check("hold.done_valid", g, 32'(dv[g]), 32'd1);
          check("hold.start_ready", g, 32'(sr[g]), 32'd0);
          check("hold.result", g, 32'(r_o[g]), 32'(got.res));
          check("hold.flags", g, {28'd0, c_o[g], v_o[g], z_o[g], n_o[g]},
                {28'd0, got.c, got.v, got.z, got.n});
        end
      end
    end
    @(negedge clk);
    start_valid = 1'b0;
    done_ready  = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check("post_hs.done_valid", g, 32'(dv[g]), 32'd0);
      check("post_hs.start_ready", g, 32'(sr[g]), 32'd1);
    end
  endtask

  task automatic reset_mid_op();
    bit any_dv[3];
    @(negedge clk);
    start_valid = 1'b1;
    op_sub      = 1'b0;
    a           = 8'h11;
    b           = 8'h22;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("rst_busy.result", g, 32'(r_o[g]), 32'd0);
      check("rst_busy.flags", g, {28'd0, c_o[g], v_o[g], z_o[g], n_o[g]}, 32'd0);
      check("rst_busy.start_ready", g, 32'(sr[g]), 32'd1);
      check("rst_busy.done_valid", g, 32'(dv[g]), 32'd0);
      any_dv[g] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) if (dv[g]) any_dv[g] = 1'b1;
    end
    for (int g = 0; g < 3; g++) check("rst_busy.no_done", g, 32'(any_dv[g]), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'h05, 8'h03, '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{1'b1, 8'h03, 8'h05, '{8'hFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[2] = '{1'b0, 8'h7F, 8'h01,
                '{Sat ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0, !Sat}};
    vecs[3] = '{1'b1, 8'h80, 8'h01,
                '{Sat ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0, Sat}};
    vecs[4] = '{1'b1, 8'h00, 8'h00, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[5] = '{1'b0, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[6] = '{1'b0, 8'h12, 8'h34, '{8'h46, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{1'b0, 8'h80, 8'h80,
                '{Sat ? 8'h80 : 8'h00, 1'b1, 1'b1, !Sat, Sat}};
    vecs[8] = '{1'b0, 8'h40, 8'h40,
                '{Sat ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0, !Sat}};
    vecs[9] = '{1'b1, 8'h55, 8'h55, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};

    rst         = 1'b1;
    start_valid = 1'b0;
    op_sub      = 1'b0;
    done_ready  = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("reset.start_ready", g, 32'(sr[g]), 32'd1);
      check("reset.done_valid", g, 32'(dv[g]), 32'd0);
      check("reset.result", g, 32'(r_o[g]), 32'd0);
      check("reset.flags", g, {28'd0, c_o[g], v_o[g], z_o[g], n_o[g]}, 32'd0);
    end

    // Table vectors; the 0x55-0x55 case holds done_ready low for 5 cycles.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, (i == 9) ? 5 : 0);
    end

    // Random operations against the reference model, with short random stalls.
    for (int i = 0; i < 8; i++) begin
      logic         rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = 1'($urandom_range(0, 1));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      run_op(rop, ra, rb, model(rop, ra, rb), $urandom_range(0, 2));
    end

    // Leave a non-zero result registered, then reset while busy.
    run_op(vecs[1].op, vecs[1].a, vecs[1].b, vecs[1].e, 0);
    reset_mid_op();
    run_op(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].e, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
